// File: rtl/tff_ctrl_pkg.sv
// Shared types and defaults for the T flip-flop counter controller.
package tff_ctrl_pkg;

  // Controller sequence: idle, preload the bank, count, signal completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  localparam int unsigned WIDTH_DEFAULT = 8;

endpackage

// File: rtl/t_ff.sv
// Single T flip-flop with asynchronous active-low clear.
module t_ff (
  input  logic CLK,
  input  logic CLR,
  input  logic T,
  output logic Q
);

  // Toggle on T, clear asynchronously while CLR is low.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/t_ff_bank.sv
// Bank of WIDTH independent T flip-flops sharing clock and clear.
module t_ff_bank import tff_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] T_vec,
  output logic [WIDTH-1:0] Q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    t_ff u_tff (
      .CLK (CLK),
      .CLR (CLR),
      .T   (T_vec[g]),
      .Q   (Q[g])
    );
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer generating toggle enables for a T flip-flop bank used as an
// up/down counter with start/abort control, done pulse and auto-reload.
// Optional macro TFF_CTRL_PAUSE_EN adds a 'pause' input that stalls RUN.
module tff_count_ctrl import tff_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             start,
  input  logic             mode_down,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] term,
  input  logic             abort,
`ifdef TFF_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] T_vec,
  output logic             busy,
  output logic             done
);

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  logic [WIDTH-1:0] term_q;
  logic             mode_down_q;
  logic             auto_reload_q;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] up_tog;
  logic [WIDTH-1:0] dn_tog;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] q;
  logic             run_hold;
  logic             match;
  logic             launch;

`ifdef TFF_CTRL_PAUSE_EN
  assign run_hold = pause;
`else
  assign run_hold = 1'b0;
`endif

  assign start_val = mode_down_q ? term_q : '0;
  assign end_val   = mode_down_q ? '0 : term_q;
  assign match     = (count == end_val);
  assign launch    = (state == IDLE) && start && !abort;

  // Carry / borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_tog    = '0;
    dn_tog    = '0;
    up_tog[0] = 1'b1;
    dn_tog[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      up_tog[i] = up_tog[i-1] & count[i-1];
      dn_tog[i] = dn_tog[i-1] & ~count[i-1];
    end
  end

  // Next-state and toggle-enable decode; abort overrides everything outside IDLE.
  always_comb begin
    state_next = state;
    t_vec      = '0;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        t_vec      = count ^ start_val;
        state_next = RUN;
      end
      RUN: begin
        if (run_hold) begin
          state_next = RUN;
        end else if (match) begin
          state_next = DONE;
        end else begin
          t_vec = mode_down_q ? dn_tog : up_tog;
        end
      end
      DONE: begin
        state_next = auto_reload_q ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
      t_vec      = '0;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Run parameters are captured once at launch and frozen for the run.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      term_q        <= '0;
      mode_down_q   <= 1'b0;
      auto_reload_q <= 1'b0;
    end else if (launch) begin
      term_q        <= term;
      mode_down_q   <= mode_down;
      auto_reload_q <= auto_reload;
    end
  end

  // Registered done: high exactly for the cycle spent in DONE.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      done <= 1'b0;
    end else begin
      done <= (state_next == DONE);
    end
  end

  assign busy  = (state != IDLE);
  assign T_vec = t_vec;
  assign count = q;

  t_ff_bank #(.WIDTH(WIDTH)) u_bank (
    .CLK   (CLK),
    .CLR   (CLR),
    .T_vec (t_vec),
    .Q     (q)
  );

endmodule
